// File: rtl/jerky_pkg.sv
// Shared types and sequence helpers for the period-14 jerky counter stream.
package jerky_pkg;

  localparam int unsigned JERKY_PERIOD = 14;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } jerky_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } jerky_anchor_t;

  // Even indices carry 1; odd index p carries 1 << ((p >> 1) + 1).
  function automatic logic [7:0] jerky_value(input logic [3:0] p);
    logic [7:0] v;
    if (!p[0]) v = 8'h01;
    else       v = 8'h01 << (4'(p[3:1]) + 4'd1);
    return v;
  endfunction

  function automatic logic [3:0] jerky_next(input logic [3:0] p);
    return (p >= 4'(JERKY_PERIOD - 1)) ? 4'd0 : p + 4'd1;
  endfunction

  // A one-hot value other than 1 pins the phase: 1 << k sits at index 2k-1.
  function automatic jerky_anchor_t jerky_anchor(input logic [7:0] v);
    jerky_anchor_t a;
    a = '0;
    if ((v != 8'h00) && (v != 8'h01) && ((v & (v - 8'h01)) == 8'h00)) begin
      a.valid = 1'b1;
      for (int k = 1; k < 8; k++) begin
        if (v[k]) a.idx = 4'(2 * k - 1);
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/jerky_expect.sv
// Combinational map from the current sequence index to the value due next.
module jerky_expect
  import jerky_pkg::*;
(
  input  logic [3:0] position,
  output logic [7:0] expected_c
);

  always_comb begin
    expected_c = jerky_value(jerky_next(position));
  end

endmodule

// File: rtl/jerky_checker.sv
// Receive-side jerky stream monitor: hunts phase, confirms, then flywheels
// along the sequence counting mismatches while locked.
module jerky_checker
  import jerky_pkg::*;
#(
  parameter int unsigned CONFIRM_N = 2,
  parameter int unsigned LOSS_N    = 3,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [7:0]       count,
  input  logic             clear_err,
  output logic             locked,
  output logic             mismatch,
  output logic [3:0]       position,
  output logic [7:0]       expected,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned MATCH_W = 3;
  localparam int unsigned MISS_W  = 4;

  jerky_state_t       state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d, match_inc;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic [3:0]         position_d, pos_adv;
  logic [7:0]         expected_d, next_val_c;
  logic [ERR_W-1:0]   err_d;
  logic               locked_d, mismatch_d, err_inc, seq_hit;
  jerky_anchor_t      anchor;

  // Expected value is derived from the index being committed this edge.
  jerky_expect u_expect (
    .position   (position_d),
    .expected_c (next_val_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      position  <= '0;
      expected  <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= locked_d;
      mismatch  <= mismatch_d;
      position  <= position_d;
      expected  <= expected_d;
      err_count <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    miss_d     = miss_q;
    position_d = position;
    mismatch_d = 1'b0;
    err_inc    = 1'b0;
    err_d      = err_count;
    pos_adv    = jerky_next(position);
    seq_hit    = (count == jerky_value(pos_adv));
    anchor     = jerky_anchor(count);
    match_inc  = match_q + MATCH_W'(1);
    miss_inc   = miss_q + MISS_W'(1);

    if (sample_en) begin
      unique case (state_q)
        HUNT: begin
          if (anchor.valid) begin
            state_d    = CONFIRM;
            position_d = anchor.idx;
            match_d    = '0;
          end
        end
        CONFIRM: begin
          if (seq_hit) begin
            position_d = pos_adv;
            if (match_inc == MATCH_W'(CONFIRM_N)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else if (anchor.valid) begin
            // Mismatch while confirming: treat the sample as a fresh anchor.
            position_d = anchor.idx;
            match_d    = '0;
          end else begin
            state_d = HUNT;
            match_d = '0;
          end
        end
        LOCKED: begin
          position_d = pos_adv;
          if (seq_hit) begin
            miss_d = '0;
          end else begin
            mismatch_d = 1'b1;
            err_inc    = 1'b1;
            if (miss_inc == MISS_W'(LOSS_N)) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end

    // Clear takes priority over a coincident counted mismatch.
    if (clear_err) begin
      err_d = '0;
    end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
      err_d = err_count + ERR_W'(1);
    end

    locked_d   = (state_d == LOCKED);
    expected_d = (state_d == HUNT) ? 8'h00 : next_val_c;
  end

endmodule

// File: tb/tb_jerky_checker.sv
// Directed self-checking bench for jerky_checker (default widths plus an ERR_W=2 copy).
module tb_jerky_checker;

  logic        clock;
  logic        reset;
  logic        sample_en;
  logic [7:0]  count;
  logic        clear_err;
  logic        locked, mismatch;
  logic [3:0]  position;
  logic [7:0]  expected;
  logic [15:0] err_count;
  logic        locked2, mismatch2;
  logic [3:0]  position2;
  logic [7:0]  expected2;
  logic [1:0]  err_count2;

  int n_vec;
  int n_err;
  int p;
  int mm_seen;

  jerky_checker #(.CONFIRM_N(2), .LOSS_N(3), .ERR_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .sample_en (sample_en),
    .count     (count),
    .clear_err (clear_err),
    .locked    (locked),
    .mismatch  (mismatch),
    .position  (position),
    .expected  (expected),
    .err_count (err_count)
  );

  jerky_checker #(.CONFIRM_N(2), .LOSS_N(3), .ERR_W(2)) dut_sat (
    .clock     (clock),
    .reset     (reset),
    .sample_en (sample_en),
    .count     (count),
    .clear_err (clear_err),
    .locked    (locked2),
    .mismatch  (mismatch2),
    .position  (position2),
    .expected  (expected2),
    .err_count (err_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] seqv(input int idx);
    int sh;
    if (idx % 2 == 0) return 8'h01;
    sh = idx / 2 + 1;
    return 8'(32'd1 << sh);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] v, input logic en);
    count     = v;
    sample_en = en;
    @(posedge clock);
    #1;
    if (mismatch) mm_seen++;
  endtask

  task automatic feed_good();
    p = (p + 1) % 14;
    step(seqv(p), 1'b1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; p = 0; mm_seen = 0;
    reset = 1'b0; sample_en = 1'b0; count = 8'h00; clear_err = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_locked",   32'(locked),    32'd0);
    check("rst_mismatch", 32'(mismatch),  32'd0);
    check("rst_position", 32'(position),  32'd0);
    check("rst_expected", 32'(expected),  32'd0);
    check("rst_err",      32'(err_count), 32'd0);
    reset = 1'b1;

    // Acquisition: leading 1s are ambiguous, 2 anchors, 4 completes confirm.
    step(8'h01, 1'b1);
    check("hunt_pos", 32'(position), 32'd0);
    check("hunt_exp", 32'(expected), 32'd0);
    step(8'h01, 1'b1);
    step(8'h02, 1'b1);
    check("anchor_pos", 32'(position), 32'd1);
    check("anchor_exp", 32'(expected), 32'h01);
    check("anchor_lock", 32'(locked), 32'd0);
    step(8'h01, 1'b1);
    check("conf_pos", 32'(position), 32'd2);
    check("conf_exp", 32'(expected), 32'h04);
    check("conf_lock", 32'(locked), 32'd0);
    step(8'h04, 1'b1);
    check("lock_rise", 32'(locked), 32'd1);
    check("lock_pos", 32'(position), 32'd3);
    p = 3;
    repeat (10) feed_good();
    check("pos13", 32'(position), 32'd13);
    check("exp_after13", 32'(expected), 32'h01);
    feed_good();
    check("wrap_pos", 32'(position), 32'd0);
    check("wrap_exp", 32'(expected), 32'h02);
    mm_seen = 0;
    repeat (100) feed_good();
    check("clean_mm", 32'(mm_seen), 32'd0);
    check("clean_err", 32'(err_count), 32'd0);
    check("clean_lock", 32'(locked), 32'd1);
    check("clean_pos", 32'(position), 32'(p));

    // Single corrupted 1 while locked.
    if (seqv((p + 1) % 14) != 8'h01) feed_good();
    p = (p + 1) % 14;
    step(8'h03, 1'b1);
    check("inj_mm", 32'(mismatch), 32'd1);
    check("inj_err", 32'(err_count), 32'd1);
    check("inj_pos", 32'(position), 32'(p));
    check("inj_lock", 32'(locked), 32'd1);
    feed_good();
    check("inj_pulse_end", 32'(mismatch), 32'd0);
    p = (p + 1) % 14; step(8'h00, 1'b1);
    p = (p + 1) % 14; step(8'h00, 1'b1);
    check("miss_cleared_lock", 32'(locked), 32'd1);
    check("miss_cleared_err", 32'(err_count), 32'd3);
    feed_good();

    // Three consecutive misses drop lock on the third.
    p = (p + 1) % 14; step(8'h00, 1'b1);
    p = (p + 1) % 14; step(8'h00, 1'b1);
    check("loss2_lock", 32'(locked), 32'd1);
    p = (p + 1) % 14; step(8'h00, 1'b1);
    check("loss_lock", 32'(locked), 32'd0);
    check("loss_mm", 32'(mismatch), 32'd1);
    check("loss_err", 32'(err_count), 32'd6);
    check("loss_exp", 32'(expected), 32'd0);
    step(8'h10, 1'b1);
    check("reanchor_pos", 32'(position), 32'd7);
    check("reanchor_exp", 32'(expected), 32'h01);
    step(8'h01, 1'b1);
    check("reconf_lock", 32'(locked), 32'd0);
    step(8'h20, 1'b1);
    check("relock", 32'(locked), 32'd1);
    check("relock_pos", 32'(position), 32'd9);
    p = 9;

    // sample_en gaps hold everything.
    feed_good();
    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    check("gap_pos", 32'(position), 32'd10);
    check("gap_mm", 32'(mismatch), 32'd0);
    check("gap_lock", 32'(locked), 32'd1);
    feed_good();
    check("gap_resume_pos", 32'(position), 32'd11);
    check("gap_resume_mm", 32'(mismatch), 32'd0);
    check("gap_err", 32'(err_count), 32'd6);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("async_lock", 32'(locked), 32'd0);
    check("async_pos", 32'(position), 32'd0);
    check("async_err", 32'(err_count), 32'd0);
    check("async_exp", 32'(expected), 32'd0);
    #1 reset = 1'b1;

    // Confirm-phase re-anchor.
    step(8'h04, 1'b1);
    check("c_anchor_pos", 32'(position), 32'd3);
    step(8'h20, 1'b1);
    check("c_reanchor_pos", 32'(position), 32'd9);
    check("c_reanchor_lock", 32'(locked), 32'd0);
    check("c_reanchor_exp", 32'(expected), 32'h01);
    check("c_reanchor_err", 32'(err_count), 32'd0);
    step(8'h01, 1'b1);
    check("c_exp64", 32'(expected), 32'h40);
    step(8'h40, 1'b1);
    check("c_lock", 32'(locked), 32'd1);
    p = 11;

    // Saturation on the narrow counter, then clear beating a mismatch.
    repeat (5) begin
      p = (p + 1) % 14;
      step(8'h00, 1'b1);
      feed_good();
    end
    check("sat_wide", 32'(err_count), 32'd5);
    check("sat_narrow", 32'(err_count2), 32'd3);
    check("sat_lock", 32'(locked2), 32'd1);
    p = (p + 1) % 14;
    clear_err = 1'b1;
    step(8'h00, 1'b1);
    clear_err = 1'b0;
    check("clr_mm", 32'(mismatch), 32'd1);
    check("clr_wide", 32'(err_count), 32'd0);
    check("clr_narrow", 32'(err_count2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jerky_checker.md
Name: jerky_checker

Overview:
- Receive-side monitor for the 8-bit jerky counter stream.
- The stream is a period-14 sequence: 1,2,1,4,1,8,1,16,1,32,1,64,1,128, then repeat.
- The block hunts for sequence phase, confirms lock, then flywheels along the sequence, flagging and counting mismatches.
- It sits on the consumer side of any jerky-count bus and gives the verification bench a self-checking sink.

Parameters:
- CONFIRM_N, 2: consecutive matches needed in CONFIRM before LOCKED (1..7).
- LOSS_N, 3: consecutive mismatches in LOCKED before dropping to HUNT (1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- sample_en  in  1  count is valid this cycle.
- count  in  8  observed jerky counter value.
- clear_err  in  1  synchronous clear of err_count.
- locked  out  1  high while the FSM is in LOCKED.
- mismatch  out  1  one-cycle pulse: the last accepted sample mismatched while LOCKED.
- position  out  4  sequence index (0..13) of the last accepted sample.
- expected  out  8  value expected at the next accepted sample (0 when not CONFIRM/LOCKED).
- err_count  out  ERR_W  saturating count of LOCKED mismatches.

Behaviour:
- Reset values: state=HUNT, locked=0, mismatch=0, position=0, expected=0, err_count=0, internal match/miss counters=0.
- Sequence index p maps to value seq(p): even p -> 8'h01; odd p -> 1<<((p>>1)+1). Index 13 wraps to 0.
- All outputs are registered and update on the edge that accepts a sample (sample_en=1). Latency is 1 cycle.
- sample_en=0: all state holds and mismatch=0.
- HUNT state:
  - count == 1: phase is ambiguous; stay in HUNT.
  - count == 0 or not one-hot: stay in HUNT; no error is counted.
  - count == 1<<k with k in 1..7: set position=2k-1, match_cnt=0, go to CONFIRM, and set expected=8'h01.
- CONFIRM state:
  - Match with seq(position+1): advance position and increment match_cnt.
  - When match_cnt reaches CONFIRM_N: go to LOCKED and assert locked on that edge.
  - Mismatch: the same sample is re-evaluated as a HUNT sample in the same cycle. A valid anchor re-enters CONFIRM at the new phase; otherwise the FSM goes to HUNT.
  - No errors are counted in CONFIRM.
- LOCKED state:
  - Match: advance position and set miss_cnt=0.
  - Mismatch: pulse mismatch, err_count+1 (saturating at all-ones), and still advance position (flywheel), miss_cnt+1.
  - When miss_cnt reaches LOSS_N: go to HUNT with locked=0 and expected=0. The mismatch pulse still fires on that edge.
- Wrap-around: position 13 -> 0. expected is always seq((position+1) mod 14).
- clear_err coincident with a counted mismatch: clear wins, err_count=0.
- Reset asserted mid-operation: immediate return to the reset values, independent of clock.

Decomposition:
- Package jerky_pkg:
  - localparam JERKY_PERIOD=14.
  - typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} jerky_state_t.
  - function jerky_value(logic [3:0] p) returning logic [7:0].
  - function jerky_anchor(logic [7:0] v), returning a valid flag plus index.
- One natural sub-module: jerky_expect, a combinational map from position to next expected value. The generator-side testbench can reuse it.

Test Plan:
- Reset, then a clean stream 1,1,2,1,4,1,8,... with sample_en=1 -> HUNT through the leading 1s. The 2 anchors position=1. With CONFIRM_N=2, locked rises on the edge accepting the 4. err_count stays 0 over 100 cycles. position wraps 13->0 after 128.
- Locked stream, then inject 8'h03 in place of one 1 -> mismatch pulses for exactly 1 cycle and err_count=1. position advances normally, locked stays 1, and the next correct sample clears miss_cnt.
- Locked stream, then 3 consecutive wrong values (e.g. 0,0,0) -> err_count=3 and locked falls on the third. A following 16 re-anchors at position=7, then re-locks after 2 matches.
- In CONFIRM after anchor 4 (position=3), feed 8'h20 instead of 1 -> immediate re-anchor at position=9, still CONFIRM, err_count unchanged.
- With ERR_W=2, force 5 isolated mismatches while locked -> err_count saturates at 3. clear_err in the same cycle as a mismatch -> err_count=0.
- sample_en toggled 1,0,0,1 on a locked stream with held count -> no state change while low, no mismatch, lock maintained. Async reset low mid-stream -> locked=0, position=0, err_count=0 with no clock edge.
